// File: rtl/pio_seq_pkg.sv
// pio_pattern_seq shared definitions.
// Register map, pattern modes, FSM states.
package pio_seq_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_SEED   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  typedef enum logic [1:0] {
    MODE_WALK,
    MODE_BOUNCE,
    MODE_COUNT,
    MODE_STATIC
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_STEP,
    ST_BLANK
  } state_e;

endpackage

// File: rtl/pio_pattern_seq_if.sv
// Avalon-MM bundle: config slave port plus PIO s1 master port.
// slave = sequencer side, master = fabric/CPU side.
interface pio_pattern_seq_if;

  logic [1:0]  cfg_address;
  logic        cfg_chipselect;
  logic        cfg_write_n;
  logic [31:0] cfg_writedata;
  logic [31:0] cfg_readdata;

  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  modport slave (
    input  cfg_address,
    input  cfg_chipselect,
    input  cfg_write_n,
    input  cfg_writedata,
    output cfg_readdata,
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata
  );

  modport master (
    output cfg_address,
    output cfg_chipselect,
    output cfg_write_n,
    output cfg_writedata,
    input  cfg_readdata,
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata
  );

endinterface

// File: rtl/pio_seq_prescaler.sv
// Free-running period counter; tick on the terminal count.
// A period of 0 behaves like 1 (tick every enabled cycle).
module pio_seq_prescaler #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic [W-1:0] last;

  assign last = (period == '0) ? '0 : period - W'(1);
  assign tick = en & (cnt >= last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/pio_pattern_seq.sv
// LED pattern sequencer driving PIO s1 from its own config slave.
// Optional PIO_PATTERN_SEQ_IRQ_EN adds irq output and CTRL.IRQ_EN.
module pio_pattern_seq
  import pio_seq_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int PRESCALE_W     = 26,
  parameter int DEFAULT_PERIOD = 50000000
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_pattern_seq_if.slave   bus,
  output logic               busy
`ifdef PIO_PATTERN_SEQ_IRQ_EN
  , output logic             irq
`endif
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_e                state;
  state_e                state_nxt;
  logic                  en;
  mode_e                 mode;
  logic [PRESCALE_W-1:0] period;
  logic [DATA_W-1:0]     seed;
  logic [DATA_W-1:0]     pattern;
  logic [DATA_W-1:0]     load_val;
  logic [DATA_W-1:0]     step_val;
  logic                  dir_left;
  logic                  step_dir;
  logic                  tick;
  logic                  cfg_wr;
  logic                  upd_load;
  logic                  upd_step;
  logic                  pending;

  assign cfg_wr = bus.cfg_chipselect & ~bus.cfg_write_n;

`ifdef PIO_PATTERN_SEQ_IRQ_EN
  logic irq_en;
  logic wrap;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en     <= 1'b0;
      mode   <= MODE_WALK;
      period <= PRESCALE_W'(DEFAULT_PERIOD);
      seed   <= ONE;
`ifdef PIO_PATTERN_SEQ_IRQ_EN
      irq_en <= 1'b0;
`endif
    end else if (cfg_wr) begin
      unique case (bus.cfg_address)
        REG_CTRL: begin
          en   <= bus.cfg_writedata[0];
          mode <= mode_e'(bus.cfg_writedata[2:1]);
`ifdef PIO_PATTERN_SEQ_IRQ_EN
          irq_en <= bus.cfg_writedata[3];
`endif
        end
        REG_PERIOD: period <= bus.cfg_writedata[PRESCALE_W-1:0];
        REG_SEED:   seed   <= bus.cfg_writedata[DATA_W-1:0];
        REG_STATUS: ;
      endcase
    end
  end

  always_comb begin
    bus.cfg_readdata = '0;
    unique case (bus.cfg_address)
      REG_CTRL: begin
        bus.cfg_readdata[0]   = en;
        bus.cfg_readdata[2:1] = mode;
`ifdef PIO_PATTERN_SEQ_IRQ_EN
        bus.cfg_readdata[3]   = irq_en;
`endif
      end
      REG_PERIOD: bus.cfg_readdata[PRESCALE_W-1:0] = period;
      REG_SEED:   bus.cfg_readdata[DATA_W-1:0]     = seed;
      REG_STATUS: begin
        bus.cfg_readdata[DATA_W-1:0] = pattern;
        bus.cfg_readdata[31]         = pending;
      end
    endcase
  end

  pio_seq_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state != ST_IDLE),
    .clr     ((state == ST_IDLE) |
              (cfg_wr & (bus.cfg_address == REG_PERIOD))),
    .period  (period),
    .tick    (tick)
  );

  assign load_val =
    ((mode == MODE_WALK || mode == MODE_BOUNCE) && seed == '0)
      ? ONE : seed;

  // Bounce turns before shifting so an end bit never falls off.
  always_comb begin
    step_val = pattern;
    step_dir = dir_left;
    unique case (mode)
      MODE_WALK:
        step_val = (pattern << 1) | (pattern >> (DATA_W - 1));
      MODE_BOUNCE: begin
        if (dir_left && pattern[DATA_W-1]) step_dir = 1'b0;
        else if (!dir_left && pattern[0]) step_dir = 1'b1;
        step_val = step_dir ? pattern << 1 : pattern >> 1;
      end
      MODE_COUNT:  step_val = pattern + ONE;
      MODE_STATIC: step_val = seed;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // LOAD/STEP with EN already low write 0 themselves, then idle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (en) state_nxt = ST_LOAD;
      ST_LOAD, ST_STEP:
        if (!en)       state_nxt = ST_IDLE;
        else if (tick) state_nxt = ST_STEP;
        else           state_nxt = ST_WAIT;
      ST_WAIT:
        if (!en)       state_nxt = ST_BLANK;
        else if (tick) state_nxt = ST_STEP;
      ST_BLANK:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  assign bus.pio_address = PIO_DATA_ADDR;

  always_comb begin
    bus.pio_chipselect = 1'b0;
    bus.pio_write_n    = 1'b1;
    bus.pio_writedata  = '0;
    upd_load           = 1'b0;
    upd_step           = 1'b0;
    busy               = (state != ST_IDLE);
    unique case (1'b1)
      (state == ST_LOAD): begin
        bus.pio_chipselect = 1'b1;
        bus.pio_write_n    = 1'b0;
        bus.pio_writedata  = en ? 32'(load_val) : '0;
        upd_load           = en;
      end
      (state == ST_STEP): begin
        bus.pio_chipselect = 1'b1;
        bus.pio_write_n    = 1'b0;
        bus.pio_writedata  = en ? 32'(step_val) : '0;
        upd_step           = en;
      end
      (state == ST_BLANK): begin
        bus.pio_chipselect = 1'b1;
        bus.pio_write_n    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern  <= '0;
      dir_left <= 1'b1;
    end else if (upd_load) begin
      pattern  <= load_val;
      dir_left <= 1'b1;
    end else if (upd_step) begin
      pattern  <= step_val;
      dir_left <= step_dir;
    end
  end

`ifdef PIO_PATTERN_SEQ_IRQ_EN
  always_comb begin
    wrap = 1'b0;
    unique case (mode)
      MODE_WALK:   wrap = pattern[DATA_W-1];
      MODE_BOUNCE: wrap = !dir_left && pattern[0];
      MODE_COUNT:  wrap = &pattern;
      MODE_STATIC: wrap = 1'b0;
    endcase
  end

  // A wrap in the same cycle as a STATUS write keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pending <= 1'b0;
    else if (upd_step && wrap)
      pending <= 1'b1;
    else if (cfg_wr && bus.cfg_address == REG_STATUS)
      pending <= 1'b0;
  end

  assign irq = pending & irq_en;
`else
  assign pending = 1'b0;
`endif

endmodule
